exu_fpu_sched: RTL and testbench
================================

# exu_fpu_sched

Issue scheduler and in-flight tracker for the EXU floating-point unit. Sits between FP decode and the fpnew-based FPU datapath, and decides when each FP op may enter the FPU. It handles RAW/WAW hazards on FP destination registers with a 32-entry scoreboard and tracks up to DEPTH in-flight ops by tag. It returns results to writeback with their destination register and accumulates exception flags for fcsr.

## Interface
Parameters:
- DEPTH, 4, max FP ops in flight; power of two, 2..8
- TAGW, $clog2(DEPTH), tag width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- dec_valid  in  1  FP op offered by decode
- dec_ready  out  1  op accepted this cycle
- dec_rd  in  5  FP destination register
- dec_wen  in  1  op writes an FP register
- dec_rs  in  15  {rs3,rs2,rs1} FP sources
- dec_rs_used  in  3  per-source valid
- dec_long  in  1  div/sqrt op
- fpu_in_valid  out  1  issue to FPU
- fpu_in_ready  in  1  FPU can accept
- fpu_tag  out  TAGW  tag of issued op
- fpu_out_valid  in  1  FPU result valid; always accepted
- fpu_out_tag  in  TAGW  tag of result
- fpu_status  in  5  NV,DZ,OF,UF,NX of result
- flush  in  1  pipeline flush
- fpu_flush  out  1  flush to FPU
- wb_valid  out  1  registered writeback strobe
- wb_rd  out  5  writeback register
- wb_wen  out  1  writeback writes FP reg
- fflags  out  5  sticky accrued flags
- fflags_clr  in  1  clear fflags (CSR write)
- busy  out  1  any op in flight

## Operation
- Per-tag entry: valid, rd, wen, long. Allocation pointer alloc_ptr advances by one on each issue and wraps modulo DEPTH.
- full = entry[alloc_ptr].valid.
- hazard = any used source with its scoreboard bit set, or (dec_wen and sb[dec_rd]).
- long_busy = any valid entry with long set. A second div/sqrt is blocked.
- issue_ok = dec_valid & ~hazard & ~full & ~(dec_long & long_busy) & state!=FLUSH & ~flush.
- fpu_in_valid = issue_ok. dec_ready = issue_ok & fpu_in_ready. fpu_tag = alloc_ptr.
- On accept: the entry becomes valid, sb[dec_rd] is set if dec_wen, and alloc_ptr increments.
- On fpu_out_valid, for the entry at fpu_out_tag:
  - Clear valid.
  - Clear sb[rd] if wen.
  - Register wb_rd and wb_wen; assert wb_valid the next cycle.
  - OR fpu_status into fflags.
  - A result for a non-valid tag is ignored.
- FSM states:
  - IDLE: no valid entries.
  - BUSY: at least one valid entry.
  - FLUSH: one cycle, no issue.
- FSM transitions:
  - IDLE→BUSY on accept.
  - BUSY→IDLE when the last entry retires with no accept in the same cycle.
  - Any state→FLUSH on flush.
  - FLUSH→IDLE.
- flush:
  - fpu_flush = flush (combinational).
  - Next edge: all entries and all scoreboard bits clear, alloc_ptr=0.
  - A result arriving in the flush cycle is dropped: no wb_valid, no fflags update.
  - An accept is impossible in the flush cycle.
- Simultaneous accept and retire of different tags: both take effect. The same rd cannot occur because the WAW check blocks it.
- Results may return out of order; tags are never reused while valid.
- busy = state!=IDLE.

## Timing
- Reset: dec_ready=0, fpu_in_valid=0, fpu_flush=0, wb_valid=0, wb_rd=0, wb_wen=0, fflags=0, busy=0, state=IDLE, all entries and scoreboard bits clear.
- dec_ready and fpu_in_valid are combinational from registered state and inputs.
- wb_valid follows fpu_out_valid by exactly 1 cycle.
- The scoreboard clears at the retire edge, so a dependent op issues no earlier than the cycle wb_valid is high.
- fflags updates at the retire edge.
- fflags_clr and a retire in the same cycle: fflags ends as fpu_status of that retire (clear first, then OR).
- Reset dominates flush.

## Configuration
- EXU_FPU_FFLAGS_EN defined: sticky fflags accumulation as above.
- EXU_FPU_FFLAGS_EN undefined:
  - fflags is tied to 0.
  - fpu_status and fflags_clr are ignored.
  - No flag registers are instantiated.

## Structure
- Shared package (veer_types): fpu_sched_entry_t {valid, rd, wen, long}, fpu_sched_state_e {IDLE, BUSY, FLUSH}, and the FFLAGS_W=5 constant.
- One sub-module, exu_fpu_scoreboard: 32-bit set/clear register with three-source and destination lookup, plus bulk clear on flush.

## Test plan
- Single fadd: issue rd=f3 tag0, fpu_out_valid tag0 3 cycles later → wb_valid next cycle with wb_rd=3, busy returns 0.
- RAW: issue fdiv rd=f5, then fadd rs1=f5 → dec_ready=0 until the fdiv retire edge; fadd accepted in the wb_valid cycle.
- Second fdiv while the first is in flight → blocked. An independent fmul in the same window issues with tag1.
- Fill DEPTH=4 independent ops with fpu_in_ready=1, retire out of order (tags 2,0,3,1) → fifth op blocked until tag alloc_ptr=0 frees; wb_rd sequence matches the tags.
- Flush with 3 in flight and a result on the same cycle → fpu_flush=1, no wb_valid, next cycle all scoreboard bits 0, one FLUSH cycle with dec_ready=0, then IDLE.
- fflags: retire with status NX=1, then DZ=1 → fflags=5'b01001. fflags_clr on the same cycle as a retire with OF → fflags=5'b00100 (EXU_FPU_FFLAGS_EN); fflags stays 0 without the macro.

Source files
------------

// File: rtl/veer_types.sv
// Shared types for the EXU floating-point issue scheduler: the per-tag entry
// record, the scheduler FSM states and the fcsr flag width.
package veer_types;

    localparam int FFLAGS_W = 5;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wen;
        logic       long;
    } fpu_sched_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } fpu_sched_state_e;

endpackage

// File: rtl/exu_fpu_scoreboard.sv
// 32-entry FP register scoreboard: one pending-write bit per FP register,
// set on issue, cleared on retire, bulk-cleared on flush. Looks up the three
// source registers and the destination register of the op offered by decode.
module exu_fpu_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        set_i,
    input  logic [4:0]  set_rd_i,
    input  logic        clr_i,
    input  logic [4:0]  clr_rd_i,
    input  logic [14:0] rs_i,
    input  logic [2:0]  rs_used_i,
    input  logic        rd_chk_i,
    input  logic [4:0]  rd_i,
    output logic        hazard_o
);

    logic [31:0] sb_q;
    logic [31:0] sb_d;

    // Next scoreboard: retire clear and issue set never share a register (WAW blocks it); flush wins
    always_comb begin
        sb_d = sb_q;
        if (clr_i) begin
            sb_d[clr_rd_i] = 1'b0;
        end
        if (set_i) begin
            sb_d[set_rd_i] = 1'b1;
        end
        if (flush_i) begin
            sb_d = '0;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // RAW on any used source, WAW on the destination
    always_comb begin
        hazard_o = rd_chk_i & sb_q[rd_i];
        for (int i = 0; i < 3; i++) begin
            if (rs_used_i[i] && sb_q[rs_i[i*5 +: 5]]) begin
                hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exu_fpu_sched.sv
// EXU FP issue scheduler and in-flight tracker. Gates decode into the FPU on
// scoreboard hazards, tag availability and a single outstanding div/sqrt,
// tracks in-flight ops by tag, returns results to writeback with their rd and
// accrues exception flags for fcsr.
// Optional feature: define EXU_FPU_FFLAGS_EN to build the sticky fflags
// accumulator; otherwise fflags is tied to zero and no flag state exists.
module exu_fpu_sched
    import veer_types::*;
#(
    parameter int DEPTH = 4,
    parameter int TAGW  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    output logic                dec_ready,
    input  logic [4:0]          dec_rd,
    input  logic                dec_wen,
    input  logic [14:0]         dec_rs,
    input  logic [2:0]          dec_rs_used,
    input  logic                dec_long,
    output logic                fpu_in_valid,
    input  logic                fpu_in_ready,
    output logic [TAGW-1:0]     fpu_tag,
    input  logic                fpu_out_valid,
    input  logic [TAGW-1:0]     fpu_out_tag,
    input  logic [FFLAGS_W-1:0] fpu_status,
    input  logic                flush,
    output logic                fpu_flush,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic                wb_wen,
    output logic [FFLAGS_W-1:0] fflags,
    input  logic                fflags_clr,
    output logic                busy
);

    fpu_sched_entry_t entry_q [DEPTH];
    fpu_sched_entry_t entry_d [DEPTH];
    logic [TAGW-1:0]  alloc_ptr_q;
    logic [TAGW-1:0]  alloc_ptr_d;
    fpu_sched_state_e state_q;
    fpu_sched_state_e state_d;

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] retire_mask;
    logic             long_busy;
    logic             full;
    logic             hazard;
    logic             issue_ok;
    logic             accept;
    logic             retire;
    logic             last_retire;

    logic             wb_valid_q;
    logic [4:0]       wb_rd_q;
    logic             wb_wen_q;

    // Summaries of the in-flight table
    always_comb begin
        valid_vec   = '0;
        retire_mask = '0;
        long_busy   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entry_q[i].valid;
            if (entry_q[i].valid && entry_q[i].long) begin
                long_busy = 1'b1;
            end
        end
        if (retire) begin
            retire_mask[fpu_out_tag] = 1'b1;
        end
    end

    assign full        = entry_q[alloc_ptr_q].valid;
    assign issue_ok    = dec_valid & ~hazard & ~full & ~(dec_long & long_busy)
                         & (state_q != FLUSH) & ~flush;
    assign accept      = issue_ok & fpu_in_ready;
    // Results for tags not in flight, or arriving in a flush cycle, are dropped
    assign retire      = fpu_out_valid & entry_q[fpu_out_tag].valid & ~flush;
    assign last_retire = retire & ((valid_vec & ~retire_mask) == '0);

    assign fpu_in_valid = issue_ok;
    assign dec_ready    = accept;
    assign fpu_tag      = alloc_ptr_q;
    assign fpu_flush    = flush;

    exu_fpu_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush),
        .set_i     (accept & dec_wen),
        .set_rd_i  (dec_rd),
        .clr_i     (retire & entry_q[fpu_out_tag].wen),
        .clr_rd_i  (entry_q[fpu_out_tag].rd),
        .rs_i      (dec_rs),
        .rs_used_i (dec_rs_used),
        .rd_chk_i  (dec_wen),
        .rd_i      (dec_rd),
        .hazard_o  (hazard)
    );

    // Next in-flight table and allocation pointer; accept and retire always hit different tags
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end
        alloc_ptr_d = alloc_ptr_q;
        if (retire) begin
            entry_d[fpu_out_tag].valid = 1'b0;
        end
        if (accept) begin
            entry_d[alloc_ptr_q] = '{valid: 1'b1, rd: dec_rd, wen: dec_wen, long: dec_long};
            alloc_ptr_d          = alloc_ptr_q + TAGW'(1);
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i].valid = 1'b0;
            end
            alloc_ptr_d = '0;
        end
    end

    // In-flight table registers; only the valid bits need a reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i].valid <= 1'b0;
                entry_q[i].rd    <= entry_d[i].rd;
                entry_q[i].wen   <= entry_d[i].wen;
                entry_q[i].long  <= entry_d[i].long;
            end
            alloc_ptr_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            alloc_ptr_q <= alloc_ptr_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and busy output; flush overrides every state
    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last_retire && !accept) state_d = IDLE;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = FLUSH;
        end
    end

    // Writeback strobe one cycle after retire, with the retiring op's destination
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_wen_q   <= 1'b0;
        end else begin
            wb_valid_q <= retire;
            if (retire) begin
                wb_rd_q  <= entry_q[fpu_out_tag].rd;
                wb_wen_q <= entry_q[fpu_out_tag].wen;
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_wen   = wb_wen_q;

`ifdef EXU_FPU_FFLAGS_EN
    logic [FFLAGS_W-1:0] fflags_q;
    logic [FFLAGS_W-1:0] fflags_d;

    // Clear first, then OR in this cycle's retire so a same-cycle result survives the clear
    always_comb begin
        fflags_d = fflags_clr ? '0 : fflags_q;
        if (retire) begin
            fflags_d = fflags_d | fpu_status;
        end
    end

    // Sticky accrued-flags register
    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags = fflags_q;
`else
    logic unused_fflags_inputs;
    assign unused_fflags_inputs = ^{fpu_status, fflags_clr};
    assign fflags = '0;
`endif

endmodule

// File: tb/tb_exu_fpu_sched.sv
// Directed bench for exu_fpu_sched: issue/retire sequences with a writeback
// scoreboard queue, hazard and capacity blocking, flush and fflags behaviour.
module tb_exu_fpu_sched;

    localparam int DEPTH = 4;
    localparam int TAGW  = 2;
`ifdef EXU_FPU_FFLAGS_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            dec_valid;
    logic            dec_ready;
    logic [4:0]      dec_rd;
    logic            dec_wen;
    logic [14:0]     dec_rs;
    logic [2:0]      dec_rs_used;
    logic            dec_long;
    logic            fpu_in_valid;
    logic            fpu_in_ready;
    logic [TAGW-1:0] fpu_tag;
    logic            fpu_out_valid;
    logic [TAGW-1:0] fpu_out_tag;
    logic [4:0]      fpu_status;
    logic            flush;
    logic            fpu_flush;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic            wb_wen;
    logic [4:0]      fflags;
    logic            fflags_clr;
    logic            busy;

    exu_fpu_sched #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_rd       (dec_rd),
        .dec_wen      (dec_wen),
        .dec_rs       (dec_rs),
        .dec_rs_used  (dec_rs_used),
        .dec_long     (dec_long),
        .fpu_in_valid (fpu_in_valid),
        .fpu_in_ready (fpu_in_ready),
        .fpu_tag      (fpu_tag),
        .fpu_out_valid(fpu_out_valid),
        .fpu_out_tag  (fpu_out_tag),
        .fpu_status   (fpu_status),
        .flush        (flush),
        .fpu_flush    (fpu_flush),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_wen       (wb_wen),
        .fflags       (fflags),
        .fflags_clr   (fflags_clr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rd;
        logic       wen;
    } wb_exp_t;

    wb_exp_t    exp_q[$];
    logic [4:0] m_rd  [DEPTH];
    logic       m_wen [DEPTH];
    int         mptr;
    int         n_pass;
    int         n_fail;
    int         n_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] rd, input logic wen, input logic [14:0] rs,
                         input logic [2:0] used, input logic lng);
        dec_valid   = 1'b1;
        dec_rd      = rd;
        dec_wen     = wen;
        dec_rs      = rs;
        dec_rs_used = used;
        dec_long    = lng;
    endtask

    // Offer an op, expect it accepted with the model's next tag, then drop dec_valid
    task automatic issue(input string tag, input logic [4:0] rd, input logic wen,
                         input logic [14:0] rs, input logic [2:0] used, input logic lng);
        offer(rd, wen, rs, used, lng);
        fpu_in_ready = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(dec_ready), 32'd1);
        chk({tag, "_tag"}, 32'(fpu_tag), 32'(mptr));
        m_rd[mptr]  = rd;
        m_wen[mptr] = wen;
        mptr        = (mptr + 1) % DEPTH;
        tick();
        dec_valid = 1'b0;
    endtask

    // Return a result for tag; the expected writeback is queued and checked a cycle later
    task automatic retire(input string tag, input int t, input logic [4:0] status);
        wb_exp_t e;
        fpu_out_valid = 1'b1;
        fpu_out_tag   = TAGW'(t);
        fpu_status    = status;
        exp_q.push_back('{rd: m_rd[t], wen: m_wen[t]});
        tick();
        fpu_out_valid = 1'b0;
        fpu_status    = '0;
        fflags_clr    = 1'b0;
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
        e = exp_q.pop_front();
        chk({tag, "_wbrd"}, 32'(wb_rd), 32'(e.rd));
        chk({tag, "_wbwen"}, 32'(wb_wen), 32'(e.wen));
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0; mptr = 0;
        rst = 1'b1; dec_valid = 1'b0; dec_rd = '0; dec_wen = 1'b0; dec_rs = '0;
        dec_rs_used = '0; dec_long = 1'b0; fpu_in_ready = 1'b1; fpu_out_valid = 1'b0;
        fpu_out_tag = '0; fpu_status = '0; flush = 1'b0; fflags_clr = 1'b0;
        tick();
        tick();
        chk("rst_dec_ready", 32'(dec_ready), 32'd0);
        chk("rst_in_valid", 32'(fpu_in_valid), 32'd0);
        chk("rst_fpu_flush", 32'(fpu_flush), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_wen", 32'(wb_wen), 32'd0);
        chk("rst_fflags", 32'(fflags), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Single fadd f3, result three cycles later
        issue("fadd", 5'd3, 1'b1, 15'd0, 3'b000, 1'b0);
        chk("fadd_busy", 32'(busy), 32'd1);
        tick();
        tick();
        retire("fadd_ret", 0, 5'd0);
        chk("fadd_idle", 32'(busy), 32'd0);

        // Result for a tag not in flight is ignored
        fpu_out_valid = 1'b1; fpu_out_tag = 2'd2; fpu_status = 5'b10000;
        tick();
        fpu_out_valid = 1'b0; fpu_status = '0;
        chk("stray_wbv", 32'(wb_valid), 32'd0);
        chk("stray_fflags", 32'(fflags), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);

        // RAW on an fdiv result, plus second-div blocking and an independent fmul
        issue("fdiv", 5'd5, 1'b1, 15'd0, 3'b000, 1'b1);
        offer(5'd6, 1'b1, 15'd5, 3'b001, 1'b0);
        #1;
        chk("raw_ready", 32'(dec_ready), 32'd0);
        chk("raw_inv", 32'(fpu_in_valid), 32'd0);
        tick();
        chk("raw_ready2", 32'(dec_ready), 32'd0);
        offer(5'd7, 1'b1, 15'd0, 3'b000, 1'b1);
        #1;
        chk("div2_ready", 32'(dec_ready), 32'd0);
        issue("fmul", 5'd8, 1'b1, 15'd0, 3'b000, 1'b0);
        offer(5'd6, 1'b1, 15'd5, 3'b001, 1'b0);
        #1;
        chk("raw_ready3", 32'(dec_ready), 32'd0);
        retire("fdiv_ret", 1, 5'd0);
        issue("raw_fadd", 5'd6, 1'b1, 15'd5, 3'b001, 1'b0);
        retire("fmul_ret", 2, 5'd0);
        retire("fadd2_ret", 3, 5'd0);
        chk("raw_idle", 32'(busy), 32'd0);

        // Fill all tags, retire out of order; fifth op waits for tag 0
        for (int i = 0; i < DEPTH; i++) begin
            issue("fill", 5'(10 + i), 1'b1, 15'd0, 3'b000, 1'b0);
        end
        offer(5'd14, 1'b1, 15'd0, 3'b000, 1'b0);
        #1;
        chk("full_ready", 32'(dec_ready), 32'd0);
        chk("full_inv", 32'(fpu_in_valid), 32'd0);
        retire("ooo_t2", 2, 5'd0);
        chk("full_ready2", 32'(dec_ready), 32'd0);
        retire("ooo_t0", 0, 5'd0);
        issue("fifth", 5'd14, 1'b1, 15'd0, 3'b000, 1'b0);
        retire("ooo_t3", 3, 5'd0);
        retire("ooo_t1", 1, 5'd0);
        retire("fifth_ret", 0, 5'd0);
        chk("fill_idle", 32'(busy), 32'd0);

        // Flush with three in flight and a result in the flush cycle
        issue("fl_a", 5'd20, 1'b1, 15'd0, 3'b000, 1'b0);
        issue("fl_b", 5'd21, 1'b1, 15'd0, 3'b000, 1'b0);
        issue("fl_c", 5'd22, 1'b1, 15'd0, 3'b000, 1'b0);
        flush = 1'b1; fpu_out_valid = 1'b1; fpu_out_tag = 2'd1; fpu_status = 5'b10000;
        offer(5'd23, 1'b1, 15'd0, 3'b000, 1'b0);
        #1;
        chk("fl_fpu_flush", 32'(fpu_flush), 32'd1);
        chk("fl_ready", 32'(dec_ready), 32'd0);
        chk("fl_inv", 32'(fpu_in_valid), 32'd0);
        tick();
        flush = 1'b0; fpu_out_valid = 1'b0; fpu_status = '0;
        mptr = 0;
        chk("fl_wbv", 32'(wb_valid), 32'd0);
        chk("fl_busy", 32'(busy), 32'd1);
        chk("fl_fflags", 32'(fflags), 32'd0);
        offer(5'd22, 1'b1, {5'd22, 5'd21, 5'd20}, 3'b111, 1'b0);
        #1;
        chk("fl_state_ready", 32'(dec_ready), 32'd0);
        tick();
        chk("fl_idle", 32'(busy), 32'd0);
        issue("post_fl", 5'd22, 1'b1, {5'd22, 5'd21, 5'd20}, 3'b111, 1'b0);
        retire("post_fl_ret", 0, 5'd0);

        // Sticky fflags accumulation and same-cycle clear
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        chk("ff_clr", 32'(fflags), 32'd0);
        issue("ff_a", 5'd1, 1'b1, 15'd0, 3'b000, 1'b0);
        issue("ff_b", 5'd2, 1'b0, 15'd0, 3'b000, 1'b0);
        retire("ff_nx", 1, 5'b00001);
        chk("ff_nx_val", 32'(fflags), FF_EN ? 32'h01 : 32'h00);
        retire("ff_dz", 2, 5'b01000);
        chk("ff_acc", 32'(fflags), FF_EN ? 32'h09 : 32'h00);
        issue("ff_c", 5'd3, 1'b1, 15'd0, 3'b000, 1'b0);
        fflags_clr = 1'b1;
        retire("ff_of", 3, 5'b00100);
        chk("ff_clr_or", 32'(fflags), FF_EN ? 32'h04 : 32'h00);
        chk("end_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
